// File: rtl/tone_arbiter.sv
// Shares one square-wave tone generator and speaker pin among NREQ prioritized sources.
// Latency: grant and owner appear 1 cycle after req is sampled; ownership changes only at a period end.
// Backpressure: none; a requester simply waits until a period boundary or the end of the silent gap.
module tone_arbiter #(
  parameter int NREQ       = 4,
  parameter int DIV_W      = 15,
  parameter int GAP_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DIV_W-1:0] div_flat,
  output logic [NREQ-1:0]       grant,
  output logic [2:0]            owner,
  output logic                  busy,
  output logic                  speaker
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_q;
  logic [IW-1:0]    own_q;
  logic [NREQ-1:0]  grant_q;
  logic             busy_q;
  logic             spk_q;
  logic [DIV_W-1:0] cnt_q;
  logic [GW-1:0]    gap_q;

  logic [DIV_W-1:0] div_a [NREQ];
  logic [IW-1:0]    win;
  logic [NREQ-1:0]  higher;
  logic             release_now;

  for (genvar g = 0; g < NREQ; g++) begin : g_div
    assign div_a[g] = div_flat[g*DIV_W +: DIV_W];
  end

  // Fixed-priority winner (lowest set index) and the release condition for the current owner.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
    higher      = req & ((ONE << own_q) - ONE);
    release_now = !req[own_q] || (higher != '0);
  end

  // Arbitration FSM and tone generator; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      spk_q   <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          spk_q   <= 1'b0;
          grant_q <= '0;
          if (req != '0) begin
            state_q <= PLAY;
            own_q   <= win;
            grant_q <= ONE << win;
            cnt_q   <= div_a[win];
            busy_q  <= 1'b1;
          end
        end
        PLAY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (spk_q && release_now) begin
            // Falling toggle that ends a full period: hand over through a silent gap.
            state_q <= GAP;
            spk_q   <= 1'b0;
            grant_q <= '0;
            own_q   <= '0;
            gap_q   <= GW'(GAP_CYCLES - 1);
          end else begin
            // Divider is sampled live so the owner can sweep pitch.
            cnt_q <= div_a[own_q];
            spk_q <= ~spk_q;
          end
        end
        GAP: begin
          spk_q   <= 1'b0;
          grant_q <= '0;
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else if (req != '0) begin
            state_q <= PLAY;
            own_q   <= win;
            grant_q <= ONE << win;
            cnt_q   <= div_a[win];
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          spk_q   <= 1'b0;
          grant_q <= '0;
          own_q   <= '0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign owner   = 3'(own_q);
  assign busy    = busy_q;
  assign speaker = spk_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with NREQ=4, DIV_W=15, GAP_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// Every expected value below is hand-derived from the cycle timeline.
module tb_tone_arbiter;

  localparam int NREQ = 4;
  localparam int DIV_W = 15;
  localparam int GAP = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] div_flat;
  logic [NREQ-1:0]       grant;
  logic [2:0]            owner;
  logic                  busy;
  logic                  speaker;

  int n_tests = 0;
  int n_fail  = 0;

  tone_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .div_flat(div_flat),
    .grant(grant), .owner(owner), .busy(busy), .speaker(speaker)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int idx, input int val);
    div_flat[idx*DIV_W +: DIV_W] = DIV_W'(val);
  endtask

  // Starting right after the grant edge, check n cycles of a square wave with the given half-period.
  task automatic run_spk(input string tag, input int half, input int n);
    for (int k = 1; k <= n; k++) begin
      tick(1);
      chk(tag, 32'(speaker), 32'((k / half) % 2));
    end
  endtask

  task automatic drain(input string tag);
    int waited;
    req = '0;
    waited = 0;
    while (busy && waited < 300) begin
      tick(1);
      waited++;
    end
    chk(tag, 32'(busy), 32'd0);
    chk({tag, "_spk"}, 32'(speaker), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    div_flat = '0;
    set_div(0, 2);

    // 1. reset state, release, asynchronous reset mid-PLAY
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_spk", 32'(speaker), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(3);
    chk("t1_spk_hi", 32'(speaker), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_grant", 32'(grant), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_spk", 32'(speaker), 32'd0);
    req = '0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2. single source, div=3 -> period 8
    set_div(2, 3);
    req = 4'b0100;
    tick(1);
    chk("t2_grant", 32'(grant), 32'b0100);
    chk("t2_owner", 32'(owner), 32'd2);
    chk("t2_spk0", 32'(speaker), 32'd0);
    run_spk("t2_spk", 4, 16);
    drain("t2_idle");

    // 3. simultaneous requests -> lowest index wins
    set_div(1, 2);
    set_div(3, 5);
    req = 4'b1010;
    tick(1);
    chk("t3_grant", 32'(grant), 32'b0010);
    chk("t3_owner", 32'(owner), 32'd1);
    run_spk("t3_spk", 3, 12);
    drain("t3_idle");

    // 4. preemption by source 0 two cycles into the high half
    set_div(2, 3);
    set_div(0, 1);
    req = 4'b0100;
    tick(1);
    chk("t4_grant", 32'(grant), 32'b0100);
    tick(6);
    chk("t4_spk_hi", 32'(speaker), 32'd1);
    req = 4'b0101;
    tick(1);
    chk("t4_hold_spk", 32'(speaker), 32'd1);
    chk("t4_hold_grant", 32'(grant), 32'b0100);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("t4_gap_grant", 32'(grant), 32'd0);
      chk("t4_gap_spk", 32'(speaker), 32'd0);
      chk("t4_gap_busy", 32'(busy), 32'd1);
    end
    tick(1);
    chk("t4_new_grant", 32'(grant), 32'b0001);
    chk("t4_new_owner", 32'(owner), 32'd0);
    run_spk("t4_spk", 2, 8);
    drain("t4_idle");

    // 5. owner drops during low half: high half still plays, then gap, then IDLE
    set_div(3, 2);
    req = 4'b1000;
    tick(1);
    chk("t5_grant", 32'(grant), 32'b1000);
    chk("t5_owner", 32'(owner), 32'd3);
    tick(1);
    req = '0;
    tick(1);
    chk("t5_lo", 32'(speaker), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t5_hi", 32'(speaker), 32'd1);
      chk("t5_hi_grant", 32'(grant), 32'b1000);
    end
    tick(1);
    chk("t5_gap_grant", 32'(grant), 32'd0);
    chk("t5_gap_spk", 32'(speaker), 32'd0);
    chk("t5_gap_busy", 32'(busy), 32'd1);
    tick(3);
    chk("t5_gap_end_busy", 32'(busy), 32'd1);
    tick(1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_spk", 32'(speaker), 32'd0);

    // 6. live pitch sweep 3 -> 7 mid low half
    set_div(1, 3);
    req = 4'b0010;
    tick(1);
    chk("t6_grant", 32'(grant), 32'b0010);
    tick(2);
    set_div(1, 7);
    tick(1);
    chk("t6_lo", 32'(speaker), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("t6_hi", 32'(speaker), 32'd1);
      chk("t6_hi_grant", 32'(grant), 32'b0010);
    end
    tick(1);
    chk("t6_fall_spk", 32'(speaker), 32'd0);
    chk("t6_no_gap_grant", 32'(grant), 32'b0010);
    chk("t6_no_gap_busy", 32'(busy), 32'd1);
    run_spk("t6_spk8", 8, 16);
    drain("t6_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares one square-wave tone generator and its speaker pin among NREQ sound sources, such as a siren, an alarm beep and a melody player.
- Each source presents a request and a live half-period divider.
- The block selects the winner by fixed priority, where index 0 is highest.
- It drives the speaker from the winner's divider.
- Ownership changes only on a full-period boundary, followed by a forced silent gap, so the output never glitches.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DIV_W, 15, width of each divider value.
- GAP_CYCLES, 1024, silent cycles between owners (must be >=1).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-source request, level-sensitive.
- div_flat  input  NREQ*DIV_W  packed dividers; source i occupies bits [i*DIV_W +: DIV_W].
- grant  output  NREQ  one-hot current owner; all zero when not playing.
- owner  output  3  binary index of the current owner; 0 when not playing.
- busy  output  1  high in PLAY or GAP.
- speaker  output  1  square-wave tone output.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset (asynchronous, at any time including mid-PLAY or mid-GAP): all of the following clear immediately, without waiting for a clock edge:
  - state=IDLE, grant=0, owner=0, busy=0, speaker=0;
  - tone counter=0, gap counter=0.
- Registers: all outputs are registered; none are combinational from inputs.
- Priority: the winner is the lowest set index of req.
- State machine, states IDLE, PLAY, GAP.
- IDLE:
  - speaker=0, grant=0.
  - If req!=0 at an edge: go to PLAY, owner<=winner, grant<=onehot(winner), counter<=div[winner], speaker stays 0.
  - grant is therefore visible 1 cycle after req is sampled.
- PLAY, tone generation:
  - When counter!=0: counter<=counter-1.
  - When counter==0: counter<=div[owner] and speaker<=~speaker.
  - The divider is sampled live at each reload, so the owner may sweep pitch.
  - Half-period is div+1 cycles; full period is 2*(div+1).
  - div=0 gives a toggle every cycle.
- PLAY, decision point:
  - The decision point is the edge where counter==0 and speaker==1, i.e. the falling toggle that completes a period.
  - At the decision point, if req[owner]==0 or any higher-priority req is set: go to GAP, grant<=0, owner<=0, gap counter<=GAP_CYCLES-1. The speaker falls to 0 on this same edge.
  - Otherwise stay in PLAY.
  - Changes to req at any other time are ignored until the next decision point.
- Owner drop behaviour: if the owner drops req during the low half, the block still plays the following high half, then releases.
- GAP:
  - speaker=0, grant=0, busy=1. The gap counter decrements each cycle.
  - When the gap counter is 0: if req!=0, go to PLAY with a fresh winner, loading exactly as from IDLE; otherwise go to IDLE.
  - The GAP lasts exactly GAP_CYCLES cycles.
  - A requester that re-asserts during GAP is arbitrated only at GAP end.
- Re-grant after release: if the released owner is still the highest request when GAP ends, it is re-granted.
- Width rules: counters are unsigned, DIV_W and ceil(log2(GAP_CYCLES)) bits wide, with no overflow paths.
- Output relations: busy = (state!=IDLE). In PLAY, grant=onehot(owner).

Test Plan (NREQ=4, DIV_W=15, GAP_CYCLES=4):
1. Reset and release: hold rst_n=0 with req=4'b1111, then release. Assert rst_n=0 again mid-PLAY -> grant, busy and speaker go to 0 asynchronously, before the next clk edge.
2. Single source: req=4'b0100, div2=3 -> grant=4'b0100 and owner=2 one cycle later; speaker low 4 cycles, high 4 cycles, period 8, repeating.
3. Simultaneous requests: req=4'b1010 asserted in IDLE -> grant=4'b0010, owner=1; speaker period is 2*(div1+1).
4. Preemption: source 2 playing with div2=3; req[0] rises 2 cycles into the high half -> speaker completes that high half and falls; grant=0 for 4 cycles; then grant=4'b0001 at div0.
5. Release to IDLE: source 3 playing alone; req[3] drops during the low half -> the high half still plays, then 4-cycle GAP, then IDLE with busy=0 and speaker=0.
6. Live sweep: source 1 playing, div1 changed 3->7 mid-half -> the current half-period finishes at 4 cycles; the next half-period is 8 cycles; no GAP occurs and grant is unchanged.
